// File: rtl/framer_pkg.sv
// rtl/framer_pkg.sv - state type, configuration check and round/saturate helpers
// shared by framer_windower and its sub-modules.
package framer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_EMIT,
        ST_HOP
    } state_e;

    function automatic logic signed [63:0] round_const(input int coef_w);
        return 64'sd1 <<< (coef_w - 2);
    endfunction

    function automatic logic cfg_valid(input int frame_len, input int hop_len, input int max_frame);
        return (frame_len >= 2) && (frame_len <= max_frame) && (hop_len >= 1) && (hop_len <= frame_len);
    endfunction

    // Q1.(coef_w-1) product back to sample scale: round half up, then clamp.
    function automatic logic signed [63:0] round_sat(input logic signed [63:0] prod,
                                                     input int data_w, input int coef_w);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = (prod + round_const(coef_w)) >>> (coef_w - 1);
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/framer_sample_ram.sv
// rtl/framer_sample_ram.sv - simple dual-port RAM, one write port, one synchronous read port.
// rd_en low holds the read register so the read stage can stall.
module framer_sample_ram #(
    parameter int W     = 16,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/framer_windower.sv
// rtl/framer_windower.sv - circular-buffer framer with run-time window for the MFCC front end.
// Define FRAMER_WINDOW_EN to build the coefficient RAM and multiplier; otherwise rectangular window.
module framer_windower
    import framer_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int MAX_FRAME = 256,
    parameter int ADDR_W    = $clog2(MAX_FRAME)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [ADDR_W:0]   frame_len,
    input  logic [ADDR_W:0]   hop_len,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              coef_wr_en,
    input  logic [ADDR_W-1:0] coef_wr_addr,
    input  logic [COEF_W-1:0] coef_wr_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_first,
    output logic              out_last,
    output logic              cfg_err,
    output logic              busy
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_base_q, rd_base_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [ADDR_W:0]     rd_idx_q, rd_idx_d;
    logic [ADDR_W:0]     fl_q, fl_d;
    logic [ADDR_W:0]     hl_q, hl_d;
    logic                armed_q, armed_d;
    logic                cfg_err_q, cfg_err_d;
    logic                s1_valid_q, s1_valid_d;
    logic                s1_first_q, s1_first_d;
    logic                s1_last_q, s1_last_d;
    logic                out_valid_q, out_valid_d;
    logic                out_first_q, out_first_d;
    logic                out_last_q, out_last_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;

    logic                stall, in_fire, issue, last_issue, cfg_ok, rd_en;
    logic [ADDR_W:0]     target;
    logic [ADDR_W-1:0]   rd_addr;
    logic [DATA_W-1:0]   samp_rd;
    logic [DATA_W-1:0]   win_data;

    // A held output freezes both pipeline stages and the read issue.
    assign stall      = out_valid_q && !out_ready;
    assign in_ready   = (state_q == ST_FILL) ||
                        ((state_q == ST_HOP) && !s1_valid_q && !out_valid_q);
    assign in_fire    = in_valid && in_ready;
    assign issue      = (state_q == ST_EMIT) && !stall;
    assign last_issue = issue && (rd_idx_q == fl_q - 1'b1);
    assign cfg_ok     = cfg_valid(int'(frame_len), int'(hop_len), MAX_FRAME);
    assign target     = (state_q == ST_FILL) ? fl_q : hl_q;
    assign rd_en      = !stall;
    assign rd_addr    = rd_base_q + rd_idx_q[ADDR_W-1:0];

    framer_sample_ram #(.W(DATA_W), .DEPTH(MAX_FRAME), .AW(ADDR_W)) u_sample_ram (
        .clk     (clk),
        .wr_en   (in_fire),
        .wr_addr (wr_ptr_q),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (samp_rd)
    );

`ifdef FRAMER_WINDOW_EN
    logic [COEF_W-1:0]               coef_rd;
    logic signed [DATA_W+COEF_W-1:0] prod;

    framer_sample_ram #(.W(COEF_W), .DEPTH(MAX_FRAME), .AW(ADDR_W)) u_coef_ram (
        .clk     (clk),
        .wr_en   (coef_wr_en && (state_q == ST_IDLE)),
        .wr_addr (coef_wr_addr),
        .wr_data (coef_wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_idx_q[ADDR_W-1:0]),
        .rd_data (coef_rd)
    );

    assign prod     = $signed(samp_rd) * $signed(coef_rd);
    assign win_data = DATA_W'(round_sat(64'(prod), DATA_W, COEF_W));
`else
    logic unused_coef;
    assign unused_coef = ^{coef_wr_en, coef_wr_addr, coef_wr_data};
    assign win_data    = samp_rd;
`endif

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_base_d   = rd_base_q;
        cnt_d       = cnt_q;
        rd_idx_d    = rd_idx_q;
        fl_d        = fl_q;
        hl_d        = hl_q;
        armed_d     = armed_q;
        cfg_err_d   = 1'b0;

        if (!enable) begin
            armed_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    if (cfg_ok) begin
                        state_d  = ST_FILL;
                        fl_d     = frame_len;
                        hl_d     = hop_len;
                        cnt_d    = '0;
                        wr_ptr_d = '0;
                    end else if (armed_q) begin
                        cfg_err_d = 1'b1;
                        armed_d   = 1'b0;
                    end
                end
            end
            ST_FILL, ST_HOP: begin
                if (in_fire) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q + 1'b1 == target) begin
                        state_d   = ST_EMIT;
                        rd_idx_d  = '0;
                        rd_base_d = wr_ptr_q + 1'b1 - fl_q[ADDR_W-1:0];
                    end
                end
            end
            ST_EMIT: begin
                if (issue) begin
                    rd_idx_d = rd_idx_q + 1'b1;
                    if (last_issue) begin
                        cnt_d = '0;
                        if (enable) begin
                            state_d = ST_HOP;
                        end else begin
                            state_d  = ST_IDLE;
                            wr_ptr_d = '0;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_first_d  = s1_first_q;
        s1_last_d   = s1_last_q;
        out_valid_d = out_valid_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        if (!stall) begin
            s1_valid_d  = issue;
            s1_first_d  = issue && (rd_idx_q == '0);
            s1_last_d   = last_issue;
            out_valid_d = s1_valid_q;
            out_first_d = s1_first_q;
            out_last_d  = s1_last_q;
            if (s1_valid_q) begin
                out_data_d = win_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_base_q   <= '0;
            cnt_q       <= '0;
            rd_idx_q    <= '0;
            fl_q        <= '0;
            hl_q        <= '0;
            armed_q     <= 1'b1;
            cfg_err_q   <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_base_q   <= rd_base_d;
            cnt_q       <= cnt_d;
            rd_idx_q    <= rd_idx_d;
            fl_q        <= fl_d;
            hl_q        <= hl_d;
            armed_q     <= armed_d;
            cfg_err_q   <= cfg_err_d;
            s1_valid_q  <= s1_valid_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;
    assign cfg_err   = cfg_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
